game_round_controller: RTL and testbench

- Parametrised FSM that sequences a multi-round memory game.
- Each round steps through: pattern generation → pattern display → player input → compare → inter-round gap.
- Counts rounds and correct rounds, then publishes the final score.
- Sits between the level selector and the pattern generator, pattern display, input trimmer and 7-segment score display. It replaces ad-hoc delay/loop-reset chains with explicit req/done handshakes.

---
 rtl/game_pkg.sv | 34 +++
 rtl/pattern_compare.sv | 23 ++
 rtl/game_round_controller.sv | 168 ++++++++++++++++
 tb/tb_game_round_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the memory-game datapath: FSM encoding, level codes and slot geometry.
package game_pkg;

    localparam int GAME_MAX_SLOTS = 16;
    localparam int GAME_IDX_W     = 3;

    localparam int DEF_LV1_SLOTS = 8;
    localparam int DEF_LV2_SLOTS = 12;
    localparam int DEF_LV3_SLOTS = 16;

    localparam logic [1:0] LV_INVALID = 2'd0;
    localparam logic [1:0] LV1        = 2'd1;
    localparam logic [1:0] LV2        = 2'd2;
    localparam logic [1:0] LV3        = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GEN   = 3'd1;
    localparam logic [2:0] ST_SHOW  = 3'd2;
    localparam logic [2:0] ST_INPUT = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    function automatic logic [4:0] slots_for_level(input logic [1:0] lv,
                                                   input int s1, input int s2, input int s3);
        case (lv)
            LV1:     return 5'(s1);
            LV2:     return 5'(s2);
            LV3:     return 5'(s3);
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/pattern_compare.sv
// Masked slot comparator: match is high when every slot below active_slots agrees.
module pattern_compare
    import game_pkg::*;
#(
    parameter int MAX_SLOTS = GAME_MAX_SLOTS,
    parameter int IDX_W     = GAME_IDX_W
) (
    input  logic [MAX_SLOTS*IDX_W-1:0] pattern,
    input  logic [MAX_SLOTS*IDX_W-1:0] player_inp,
    input  logic [4:0]                 active_slots,
    output logic                       match
);

    always_comb begin
        match = 1'b1;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if ((i < int'(active_slots)) &&
                (pattern[i*IDX_W +: IDX_W] != player_inp[i*IDX_W +: IDX_W]))
                match = 1'b0;
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the memory game: GEN -> SHOW -> INPUT -> CHECK -> GAP, repeated NUM_ROUNDS times,
// using single-cycle req pulses and done inputs that are only honoured in their own state.
module game_round_controller
    import game_pkg::*;
#(
    parameter int MAX_SLOTS      = GAME_MAX_SLOTS,
    parameter int IDX_W          = GAME_IDX_W,
    parameter int LV1_SLOTS      = DEF_LV1_SLOTS,
    parameter int LV2_SLOTS      = DEF_LV2_SLOTS,
    parameter int LV3_SLOTS      = DEF_LV3_SLOTS,
    parameter int NUM_ROUNDS     = 10,
    parameter int POINTS_PER_WIN = 10,
    parameter int SCORE_W        = 7,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 level,
    input  logic [MAX_SLOTS*IDX_W-1:0] pattern,
    input  logic [MAX_SLOTS*IDX_W-1:0] player_inp,
    output logic                       gen_req,
    input  logic                       gen_done,
    output logic                       show_req,
    input  logic                       show_done,
    output logic                       inp_req,
    input  logic                       inp_done,
    output logic [4:0]                 active_slots,
    output logic [4:0]                 round_count,
    output logic [4:0]                 win_count,
    output logic                       round_win,
    output logic [SCORE_W-1:0]         score,
    output logic                       game_over,
    output logic                       busy
);

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [2:0]                 state;
    logic [1:0]                 lvl;
    logic [MAX_SLOTS*IDX_W-1:0] pat_q;
    logic [MAX_SLOTS*IDX_W-1:0] inp_q;
    logic [TO_W-1:0]            to_cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic                       timed_out;
    logic                       match;
    logic                       win;
    logic                       timeout_hit;
    logic [4:0]                 rounds_next;
    logic [4:0]                 wins_next;

    pattern_compare #(
        .MAX_SLOTS (MAX_SLOTS),
        .IDX_W     (IDX_W)
    ) u_cmp (
        .pattern      (pat_q),
        .player_inp   (inp_q),
        .active_slots (active_slots),
        .match        (match)
    );

    assign active_slots = slots_for_level(lvl, LV1_SLOTS, LV2_SLOTS, LV3_SLOTS);
    assign game_over    = (state == ST_DONE);
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign win          = !timed_out && match;
    assign rounds_next  = round_count + 5'd1;
    assign wins_next    = win_count + {4'd0, win};
    assign timeout_hit  = (TIMEOUT_CYCLES > 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lvl         <= LV_INVALID;
            pat_q       <= '0;
            inp_q       <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            timed_out   <= 1'b0;
            round_count <= '0;
            win_count   <= '0;
            score       <= '0;
            round_win   <= 1'b0;
            gen_req     <= 1'b0;
            show_req    <= 1'b0;
            inp_req     <= 1'b0;
        end else begin
            gen_req   <= 1'b0;
            show_req  <= 1'b0;
            inp_req   <= 1'b0;
            round_win <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (level != LV_INVALID) begin
                            lvl         <= level;
                            round_count <= '0;
                            win_count   <= '0;
                            score       <= '0;
                            timed_out   <= 1'b0;
                            gen_req     <= 1'b1;
                            state       <= ST_GEN;
                        end else if (state == ST_DONE) begin
                            lvl         <= LV_INVALID;
                            round_count <= '0;
                            win_count   <= '0;
                            score       <= '0;
                            pat_q       <= '0;
                            inp_q       <= '0;
                            timed_out   <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_GEN: begin
                    if (gen_done) begin
                        pat_q    <= pattern;
                        show_req <= 1'b1;
                        state    <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (show_done) begin
                        inp_req   <= 1'b1;
                        to_cnt    <= '0;
                        timed_out <= 1'b0;
                        state     <= ST_INPUT;
                    end
                end
                ST_INPUT: begin
                    // A real inp_done takes priority over a timeout landing in the same cycle.
                    if (inp_done) begin
                        inp_q <= player_inp;
                        state <= ST_CHECK;
                    end else if (timeout_hit) begin
                        timed_out <= 1'b1;
                        state     <= ST_CHECK;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    round_count <= rounds_next;
                    win_count   <= wins_next;
                    round_win   <= win;
                    if (rounds_next == 5'(NUM_ROUNDS)) begin
                        score <= SCORE_W'(32'(wins_next) * POINTS_PER_WIN);
                        state <= ST_DONE;
                    end else begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gen_req <= 1'b1;
                        state   <= ST_GEN;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Directed-plus-random bench: drives the req/done handshakes and scores each round against a slot-rule model.
module tb_game_round_controller;

    localparam int NR  = 10;
    localparam int PPW = 10;
    localparam int GAP = 4;
    localparam int TO  = 50;
    localparam int PW  = 16 * 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    level = 2'd0;
    logic [PW-1:0] pat_bus = '0;
    logic [PW-1:0] inp_bus = '0;
    logic          gen_req, show_req, inp_req;
    logic          gen_done = 1'b0, show_done = 1'b0, inp_done = 1'b0;
    logic [4:0]    active_slots, round_count, win_count;
    logic          round_win, game_over, busy;
    logic [6:0]    score;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int exp_lvl = 0;
    int exp_rounds = 0;
    int exp_wins = 0;

    game_round_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .level        (level),
        .pattern      (pat_bus),
        .player_inp   (inp_bus),
        .gen_req      (gen_req),
        .gen_done     (gen_done),
        .show_req     (show_req),
        .show_done    (show_done),
        .inp_req      (inp_req),
        .inp_done     (inp_done),
        .active_slots (active_slots),
        .round_count  (round_count),
        .win_count    (win_count),
        .round_win    (round_win),
        .score        (score),
        .game_over    (game_over),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int slots_of(input int lv);
        case (lv)
            1:       return 8;
            2:       return 12;
            3:       return 16;
            default: return 0;
        endcase
    endfunction

    function automatic bit round_wins(input logic [PW-1:0] p, input logic [PW-1:0] q, input int n);
        for (int i = 0; i < n; i++)
            if (p[i*3 +: 3] != q[i*3 +: 3]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [PW-1:0] rnd_pat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] corrupt(input logic [PW-1:0] v, input int s);
        v[s*3 +: 3] = v[s*3 +: 3] ^ 3'($urandom_range(1, 7));
        return v;
    endfunction

    task automatic wait_for(input int which, output int n, output bit got);
        got = 1'b0;
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if ((which == 0 && gen_req) || (which == 1 && show_req) || (which == 2 && inp_req)) begin
                got = 1'b1;
                break;
            end
            step();
            n++;
        end
    endtask

    task automatic start_game(input int lv);
        level = 2'(lv);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_lvl = lv;
        exp_rounds = 0;
        exp_wins = 0;
        check("start_gen_req", gen_req, 1);
        check("start_active_slots", active_slots, slots_of(lv));
        check("start_round_count", round_count, 0);
        check("start_win_count", win_count, 0);
        check("start_score", score, 0);
    endtask

    // Walks GEN and SHOW; with bogus set, fires out-of-state done pulses and a start while busy.
    task automatic advance_to_input(input logic [PW-1:0] p, input int gw, input bit bogus);
        int n;
        bit got;
        wait_for(0, n, got);
        check("gen_req_seen", got, 1);
        if (gw >= 0) check("gen_req_latency", n, gw);
        if (bogus) begin
            show_done = 1'b1;
            level = 2'd1;
            start = 1'b1;
            step();
            show_done = 1'b0;
            start = 1'b0;
            check("show_done_in_gen_ignored", show_req, 0);
            check("start_while_busy_ignored", active_slots, slots_of(exp_lvl));
            step();
            check("still_no_show_req", show_req, 0);
        end
        pat_bus = p;
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        wait_for(1, n, got);
        check("show_req_seen", got, 1);
        if (bogus) begin
            pat_bus = ~p;
            gen_done = 1'b1;
            inp_done = 1'b1;
            step();
            gen_done = 1'b0;
            inp_done = 1'b0;
            check("gen_done_in_show_ignored", inp_req, 0);
        end
        show_done = 1'b1;
        step();
        show_done = 1'b0;
        wait_for(2, n, got);
        check("inp_req_seen", got, 1);
    endtask

    // mode 0: inp_done at once, 1: withheld until timeout, 2: inp_done on the timeout cycle
    task automatic play_round(input logic [PW-1:0] p, input logic [PW-1:0] q, input int mode,
                              input int gw, input bit bogus);
        bit w;
        advance_to_input(p, gw, bogus);
        w = (mode == 1) ? 1'b0 : round_wins(p, q, slots_of(exp_lvl));
        if (mode != 0) begin
            repeat (TO - 1) step();
            check("no_early_timeout", round_count, exp_rounds);
        end
        if (mode != 1) begin
            inp_bus = q;
            inp_done = 1'b1;
        end
        step();
        inp_done = 1'b0;
        step();
        exp_rounds++;
        exp_wins += int'(w);
        check("round_win", round_win, w);
        check("round_count", round_count, exp_rounds);
        check("win_count", win_count, exp_wins);
        check("game_over", game_over, exp_rounds == NR);
        if (exp_rounds == NR) begin
            check("final_score", score, exp_wins * PPW);
            check("busy_in_done", busy, 0);
        end
    endtask

    initial begin
        logic [PW-1:0] p, q;
        int mode;
        step();
        step();
        check("rst_gen_req", gen_req, 0);
        check("rst_active_slots", active_slots, 0);
        check("rst_round_count", round_count, 0);
        check("rst_score", score, 0);
        check("rst_game_over", game_over, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        level = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("lv0_idle_no_gen_req", gen_req, 0);
        check("lv0_idle_not_busy", busy, 0);

        // Level 2: all active slots right, slots 12..15 scrambled.
        start_game(2);
        for (int r = 0; r < NR; r++) begin
            p = rnd_pat();
            q = p;
            for (int s = 12; s < 16; s++) q = corrupt(q, s);
            play_round(p, q, 0, (r == 0) ? 0 : GAP, 1'b0);
        end
        check("lv2_score_100", score, 100);

        // Restart from DONE at level 3 with timeout, same-cycle and out-of-state done cases.
        start_game(3);
        for (int r = 0; r < NR; r++) begin
            p = rnd_pat();
            q = p;
            mode = (r == 0) ? 2 : (r == 1) ? 1 : 0;
            if (r >= 3 && $urandom_range(0, 1) == 1) q = corrupt(q, $urandom_range(0, 15));
            play_round(p, q, mode, (r == 0) ? 0 : GAP, r == 2);
        end

        level = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("done_lv0_gen_req", gen_req, 0);
        check("done_lv0_game_over", game_over, 0);
        check("done_lv0_round_count", round_count, 0);
        check("done_lv0_active_slots", active_slots, 0);
        check("done_lv0_score", score, 0);

        // Async reset in the middle of round 3's INPUT phase.
        start_game(1);
        for (int r = 0; r < 2; r++) begin
            p = rnd_pat();
            play_round(p, p, 0, (r == 0) ? 0 : GAP, 1'b0);
        end
        advance_to_input(rnd_pat(), GAP, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_round_count", round_count, 0);
        check("midrst_win_count", win_count, 0);
        check("midrst_active_slots", active_slots, 0);
        check("midrst_busy", busy, 0);
        check("midrst_inp_req", inp_req, 0);
        step();
        rst = 1'b0;
        step();

        // Level 1: slot 3 wrong in rounds 2 and 7; slots beyond 8 disturbed elsewhere.
        start_game(1);
        for (int r = 0; r < NR; r++) begin
            p = rnd_pat();
            q = p;
            if (r == 1 || r == 6) q = corrupt(q, 3);
            if (r == 3) q = corrupt(corrupt(q, 9), 15);
            play_round(p, q, 0, (r == 0) ? 0 : GAP, 1'b0);
        end
        check("lv1_win_count_8", win_count, 8);
        check("lv1_score_80", score, 80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
